// File: rtl/ct_merge_wrr.sv
// ct_merge_wrr: packet-atomic weighted round-robin N-to-1 stream merge.
// Each input is buffered in a small FIFO, so input readiness depends only on
// local occupancy. An arbiter grants whole packets to one input at a time.
// The grant stays on that input for up to `weight` packets. Words leave
// through a registered output stage that also carries the index of the
// source input.
module ct_merge_wrr #(
  parameter  int NI     = 2,
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 2,
  parameter  int WBITS  = 4,
  localparam int NIBITS = (NI > 1) ? $clog2(NI) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NI*WIDTH-1:0]   i_data,
  input  logic [NI-1:0]         i_valid,
  input  logic [NI-1:0]         i_eop,
  output logic [NI-1:0]         o_ready,
  input  logic [NI*WBITS-1:0]   i_weights,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_eop,
  output logic [NIBITS-1:0]     o_src,
  input  logic                  i_ready
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  typedef enum logic {
    S_IDLE,
    S_PKT
  } state_t;

  // FIFO storage: each entry is {data, eop}
  logic [WIDTH:0]      mem     [NI][DEPTH];
  logic [PTRW-1:0]     wr_ptr  [NI];
  logic [PTRW-1:0]     rd_ptr  [NI];
  logic [CNTW-1:0]     count   [NI];
  logic [CNTW-1:0]     count_d [NI];
  logic [NI-1:0]       ready_q;
  logic [NI-1:0]       push;
  logic [NI-1:0]       pop_vec;
  logic [NI-1:0]       empty;

  // Arbiter state and its next-state values
  state_t              state, state_d;
  logic [NIBITS-1:0]   cur, cur_d;
  logic [WBITS-1:0]    credit, credit_d;

  // Per-cycle grant decisions
  logic                scan_hit;
  logic [NIBITS-1:0]   scan_idx;
  int                  scan_pos;
  logic                load_ok;
  logic                grant_act;
  logic [NIBITS-1:0]   grant_idx;
  logic [WIDTH:0]      head;
  logic [WBITS-1:0]    weight_sel;
  logic                sel_empty;
  logic                drains;
  logic                pop;

  // Readiness is a register, so it never depends combinationally on i_ready.
  assign o_ready = ready_q;

  // Per-input FIFO status and accepted-push strobes
  always_comb begin
    for (int i = 0; i < NI; i++) begin
      empty[i] = (count[i] == '0);
      push[i]  = i_valid[i] & ready_q[i];
    end
  end

  // Round-robin scan: the first non-empty FIFO from cur+1 up to and including cur wins
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    scan_hit = 1'b0;
    scan_idx = cur;
    scan_pos = 0;
    for (int k = 1; k <= NI; k++) begin
      scan_pos = (int'(cur) + k) % NI;
      for (int i = 0; i < NI; i++) begin
        if (!scan_hit && (i == scan_pos) && !empty[i]) begin
          scan_hit = 1'b1;
          scan_idx = NIBITS'(i);
        end
      end
    end
  end

  // Grant selection: locked to cur in PKT, otherwise the scan winner when the output can load
  always_comb begin
    load_ok    = !o_valid || i_ready;
    grant_act  = (state == S_PKT) || (load_ok && scan_hit);
    grant_idx  = (state == S_PKT) ? cur : scan_idx;
    head       = '0;
    weight_sel = '0;
    sel_empty  = 1'b1;
    drains     = 1'b0;
    for (int i = 0; i < NI; i++) begin
      if (NIBITS'(i) == grant_idx) begin
        head       = mem[i][rd_ptr[i]];
        weight_sel = i_weights[WBITS*i +: WBITS];
        sel_empty  = empty[i];
        // The FIFO is empty after this pop only if no word arrives in the same cycle.
        drains     = (count[i] == CNTW'(1)) && !push[i];
      end
    end
    pop = load_ok && grant_act && !sel_empty;
    for (int i = 0; i < NI; i++) begin
      pop_vec[i] = pop && (NIBITS'(i) == grant_idx);
    end
  end

  // Arbiter next state: take a new grant in IDLE, spend credit at each packet end
  always_comb begin
    // NOTE: always_comb uses blocking '=' so that later lines read the
    // updated credit_d. Clocked blocks use '<=' so that every register
    // samples the values from before the edge.
    state_d  = state;
    cur_d    = cur;
    credit_d = credit;
    if ((state == S_IDLE) && grant_act) begin
      cur_d    = scan_idx;
      credit_d = (weight_sel == '0) ? WBITS'(1) : weight_sel;
      state_d  = S_PKT;
    end
    if (pop && head[0]) begin
      credit_d = credit_d - WBITS'(1);
      if ((credit_d == '0) || drains) begin
        state_d = S_IDLE;
      end
    end
  end

  // Arbiter registers. cur resets to the last input, so input 0 has first priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cur    <= NIBITS'(NI - 1);
      credit <= '0;
    end else begin
      state  <= state_d;
      cur    <= cur_d;
      credit <= credit_d;
    end
  end

  // Next occupancy of each FIFO
  always_comb begin
    for (int i = 0; i < NI; i++) begin
      count_d[i] = count[i] + CNTW'(push[i]) - CNTW'(pop_vec[i]);
    end
  end

  // FIFO pointers, occupancy and registered not-full flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NI; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ready_q <= '0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTRW'(1);
        end
        if (pop_vec[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTRW'(1);
        end
        count[i]   <= count_d[i];
        ready_q[i] <= (count_d[i] != CNTW'(DEPTH));
      end
    end
  end

  // FIFO data array write port
  // NOTE: the storage array has no reset. Entries are only read after they
  // have been written, because the pointers and counts are reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {i_data[WIDTH*i +: WIDTH], i_eop[i]};
      end
    end
  end

  // Output register: load on a pop, drop valid when it drains with nothing to replace it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_eop   <= 1'b0;
      o_src   <= '0;
    end else if (pop) begin
      o_valid <= 1'b1;
      o_data  <= head[WIDTH:1];
      o_eop   <= head[0];
      o_src   <= grant_idx;
    end else if (load_ok) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ct_merge_wrr.sv
// tb_ct_merge_wrr: directed scenarios plus a randomized run compared against a
// queue-based packet-level model of the weighted round-robin merge.
module tb_ct_merge_wrr;

  localparam int NI     = 2;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 2;
  localparam int WBITS  = 4;
  localparam int NIBITS = (NI > 1) ? $clog2(NI) : 1;
  localparam int DW     = NI * WIDTH;
  localparam int WW     = NI * WBITS;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DW-1:0]     i_data = '0;
  logic [NI-1:0]     i_valid = '0;
  logic [NI-1:0]     i_eop = '0;
  logic [NI-1:0]     o_ready;
  logic [WW-1:0]     i_weights = '0;
  logic              o_valid;
  logic [WIDTH-1:0]  o_data;
  logic              o_eop;
  logic [NIBITS-1:0] o_src;
  logic              i_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  ct_merge_wrr #(.NI(NI), .WIDTH(WIDTH), .DEPTH(DEPTH), .WBITS(WBITS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_eop     (i_eop),
    .o_ready   (o_ready),
    .i_weights (i_weights),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_eop     (o_eop),
    .o_src     (o_src),
    .i_ready   (i_ready)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per input plus the grant bookkeeping
  logic [WIDTH:0]    mq [NI][$];
  bit                m_busy;
  int                m_cur;
  int                m_credit;
  bit                m_ov;
  logic [WIDTH-1:0]  m_od;
  logic              m_oe;
  logic [NIBITS-1:0] m_os;
  logic [NI-1:0]     m_ready;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) mq[i].delete();
    m_busy   = 1'b0;
    m_cur    = NI - 1;
    m_credit = 0;
    m_ov     = 1'b0;
    m_od     = '0;
    m_oe     = 1'b0;
    m_os     = '0;
    m_ready  = '1;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit            load_ok;
    bit            granted;
    bit [NI-1:0]   pushed;
    logic [WIDTH:0] w;
    int            wt;
    for (int i = 0; i < NI; i++) pushed[i] = i_valid[i] && m_ready[i];
    load_ok = !m_ov || i_ready;
    granted = m_busy;
    if (!m_busy && load_ok) begin
      for (int k = 1; k <= NI; k++) begin
        int j;
        j = (m_cur + k) % NI;
        if (!granted && mq[j].size() > 0) begin
          m_cur    = j;
          wt       = int'(i_weights[WBITS*j +: WBITS]);
          m_credit = (wt == 0) ? 1 : wt;
          m_busy   = 1'b1;
          granted  = 1'b1;
        end
      end
    end
    if (load_ok && granted && mq[m_cur].size() > 0) begin
      w    = mq[m_cur].pop_front();
      m_ov = 1'b1;
      m_od = w[WIDTH:1];
      m_oe = w[0];
      m_os = NIBITS'(m_cur);
      if (w[0]) begin
        m_credit = m_credit - 1;
        if (m_credit == 0 || (mq[m_cur].size() + int'(pushed[m_cur])) == 0) m_busy = 1'b0;
      end
    end else if (load_ok) begin
      m_ov = 1'b0;
    end
    for (int i = 0; i < NI; i++) begin
      if (pushed[i]) mq[i].push_back({i_data[WIDTH*i +: WIDTH], i_eop[i]});
      m_ready[i] = (mq[i].size() != DEPTH);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    i_valid   = '0;
    i_eop     = '0;
    i_data    = '0;
    i_ready   = 1'b0;
    i_weights = '0;
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({o_valid, o_data, o_eop, o_src} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {o_valid, o_data, o_eop, o_src});
    end
    checks++;
    if (o_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 00", o_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if (o_ready !== '1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 11", o_ready);
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_valid: got %b expected 0", o_valid);
    end
  endtask

  task automatic test_single_word();
    apply_reset();
    i_ready = 1'b1;
    i_data  = {8'hA5, 8'h00};
    i_eop   = 2'b10;
    i_valid = 2'b10;
    tick();
    i_valid = '0;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_early: got o_valid=%b expected 0", o_valid);
    end
    tick();
    checks++;
    if ({o_valid, o_data, o_src, o_eop} !== {1'b1, 8'hA5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sw_word: got v=%b d=%h s=%0d e=%b expected v=1 d=a5 s=1 e=1",
               o_valid, o_data, o_src, o_eop);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_drain: got o_valid=%b expected 0", o_valid);
    end
    // Back in IDLE with cur=1, so the scan must start at input 0.
    i_data  = {8'h22, 8'h11};
    i_eop   = 2'b11;
    i_valid = 2'b11;
    tick();
    i_valid = '0;
    tick();
    checks++;
    if ({o_valid, o_src, o_data} !== {1'b1, 1'b0, 8'h11}) begin
      errors++;
      $display("FAIL sw_rr_first: got v=%b s=%0d d=%h expected v=1 s=0 d=11", o_valid, o_src, o_data);
    end
    tick();
    checks++;
    if ({o_valid, o_src, o_data} !== {1'b1, 1'b1, 8'h22}) begin
      errors++;
      $display("FAIL sw_rr_second: got v=%b s=%0d d=%h expected v=1 s=1 d=22", o_valid, o_src, o_data);
    end
  endtask

  task automatic test_wrr();
    int seen;
    int idx;
    bit found1;
    apply_reset();
    i_weights = {4'd1, 4'd3};
    i_ready   = 1'b1;
    i_eop     = 2'b11;
    i_valid   = 2'b11;
    seen = 0;
    for (int n = 0; n < 40 && seen < 12; n++) begin
      i_data = {WIDTH'(n + 128), WIDTH'(n)};
      tick();
      if (o_valid) begin
        checks++;
        if (o_src !== NIBITS'((seen % 4) == 3)) begin
          errors++;
          $display("FAIL wrr_3to1 word %0d: got src %0d expected %0d", seen, o_src, ((seen % 4) == 3));
        end
        seen++;
      end
    end
    checks++;
    if (seen != 12) begin
      errors++;
      $display("FAIL wrr_3to1_timeout: got %0d words expected 12", seen);
    end
    // Weight 0 counts as 1; it takes effect at input 0's next grant.
    i_weights = {4'd1, 4'd0};
    found1 = 1'b0;
    idx = 0;
    for (int n = 0; n < 40 && idx < 4; n++) begin
      i_data = {WIDTH'(n + 64), WIDTH'(n + 32)};
      tick();
      if (o_valid) begin
        if (!found1) begin
          if (o_src == 1'b1) found1 = 1'b1;
        end else begin
          checks++;
          if (o_src !== NIBITS'(idx % 2)) begin
            errors++;
            $display("FAIL wrr_1to1 word %0d: got src %0d expected %0d", idx, o_src, idx % 2);
          end
          idx++;
        end
      end
    end
    checks++;
    if (idx != 4) begin
      errors++;
      $display("FAIL wrr_1to1_timeout: got %0d words expected 4", idx);
    end
    i_valid = '0;
  endtask

  task automatic test_atomicity();
    logic [5:0] v0_pat;
    int w;
    int nw0;
    int bubbles;
    int viol;
    bit eop_seen;
    bit saw1;
    apply_reset();
    i_ready = 1'b1;
    v0_pat = 6'b110011;
    w = 0; nw0 = 0; bubbles = 0; viol = 0; eop_seen = 1'b0; saw1 = 1'b0;
    for (int c = 0; c < 14; c++) begin
      i_valid[1]           = 1'b1;
      i_eop[1]             = 1'b1;
      i_data[WIDTH +: WIDTH] = 8'hB0;
      if (c < 6) begin
        i_valid[0] = v0_pat[c];
        i_eop[0]   = (c == 5);
        i_data[WIDTH-1:0] = WIDTH'(8'h10 + w);
      end else begin
        i_valid[0] = 1'b0;
      end
      if (i_valid[0] && o_ready[0]) w++;
      tick();
      if (o_valid) begin
        if (o_src == 1'b0) begin
          checks++;
          if (o_data !== WIDTH'(8'h10 + nw0)) begin
            errors++;
            $display("FAIL atom_order word %0d: got %h expected %h", nw0, o_data, 8'h10 + nw0);
          end
          nw0++;
          if (o_eop) eop_seen = 1'b1;
        end else begin
          if (!eop_seen) viol++;
          saw1 = 1'b1;
        end
      end else if (nw0 > 0 && !eop_seen) begin
        bubbles++;
      end
    end
    i_valid = '0;
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL atom_interleave: got %0d foreign words expected 0", viol);
    end
    checks++;
    if (nw0 != 4) begin
      errors++;
      $display("FAIL atom_count: got %0d words expected 4", nw0);
    end
    checks++;
    if (bubbles != 2) begin
      errors++;
      $display("FAIL atom_bubbles: got %0d expected 2", bubbles);
    end
    checks++;
    if (!saw1) begin
      errors++;
      $display("FAIL atom_next_input: got no input-1 word expected one");
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int got;
    bit a;
    apply_reset();
    i_valid = 2'b01;
    i_eop   = 2'b01;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      i_data[WIDTH-1:0] = WIDTH'(acc);
      a = o_ready[0];
      tick();
      if (a) acc++;
    end
    checks++;
    if (acc != 3) begin
      errors++;
      $display("FAIL bp_accepted: got %0d expected 3", acc);
    end
    checks++;
    if (o_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready: got %b expected 0", o_ready[0]);
    end
    checks++;
    if ({o_valid, o_data} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=00", o_valid, o_data);
    end
    i_valid = '0;
    i_ready = 1'b1;
    got = 1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (o_valid) begin
        checks++;
        if (o_data !== WIDTH'(got)) begin
          errors++;
          $display("FAIL bp_drain word %0d: got %h expected %h", got, o_data, got);
        end
        got++;
      end
    end
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL bp_drain_count: got %0d words expected 3", got);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    apply_reset();
    i_weights = {4'd15, 4'd15};
    i_ready   = 1'b1;
    i_valid   = 2'b10;
    i_eop     = 2'b10;
    i_data    = {8'h77, 8'h5A};
    tick(); tick(); tick();
    checks++;
    if ({o_valid, o_src, o_eop, o_data} !== {1'b1, 1'b1, 1'b1, 8'h77}) begin
      errors++;
      $display("FAIL rm_pre: got v=%b s=%0d e=%b d=%h expected v=1 s=1 e=1 d=77",
               o_valid, o_src, o_eop, o_data);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_data, o_eop, o_src, o_ready} !== '0) begin
      errors++;
      $display("FAIL rm_async: got %h expected 0", {o_valid, o_data, o_eop, o_src, o_ready});
    end
    i_valid = 2'b11;
    i_eop   = 2'b11;
    i_data  = {8'h33, 8'h44};
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if (o_ready !== '1) begin
      errors++;
      $display("FAIL rm_ready: got %b expected 11", o_ready);
    end
    found = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin
      tick();
      if (o_valid) begin
        found = 1'b1;
        checks++;
        if ({o_src, o_data} !== {1'b0, 8'h44}) begin
          errors++;
          $display("FAIL rm_first_grant: got s=%0d d=%h expected s=0 d=44", o_src, o_data);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rm_timeout: got no output expected one");
    end
    i_valid = '0;
  endtask

  task automatic test_random();
    int rate;
    apply_reset();
    model_reset();
    rate = 100;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) i_weights = WW'($urandom);
      if (n % 250 == 0) rate = 20 + int'($urandom_range(80));
      for (int i = 0; i < NI; i++) begin
        i_valid[i] = ($urandom % 4) != 0;
        i_eop[i]   = ($urandom % 3) == 0;
      end
      i_data  = DW'($urandom);
      i_ready = int'($urandom % 100) < rate;
      model_step();
      tick();
      checks++;
      if (o_valid !== m_ov) begin
        errors++;
        $display("FAIL rnd_valid cycle %0d: got %b expected %b", n, o_valid, m_ov);
      end
      checks++;
      if (o_ready !== m_ready) begin
        errors++;
        $display("FAIL rnd_ready cycle %0d: got %b expected %b", n, o_ready, m_ready);
      end
      if (m_ov) begin
        checks++;
        if ({o_data, o_eop, o_src} !== {m_od, m_oe, m_os}) begin
          errors++;
          $display("FAIL rnd_word cycle %0d: got d=%h e=%b s=%0d expected d=%h e=%b s=%0d",
                   n, o_data, o_eop, o_src, m_od, m_oe, m_os);
        end
      end
    end
    i_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_wrr();
    test_atomicity();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ct_merge_wrr.md
# ct_merge_wrr

Packet-atomic, weighted round-robin N-to-1 merge for streaming channels, with per-input buffering and a registered output. It sits where the existing merge sits: in front of a shared link or sink, combining NI valid/ready/eop streams. Compared with the existing merge it adds:
- DEPTH-entry input FIFOs, so input readies do not depend on `i_ready`.
- Per-input packet weights supplied at runtime.
- A registered output with a source-index sideband.

## Interface
Parameters:
- NI, 2: number of inputs (≥1).
- WIDTH, 8: data width per word.
- DEPTH, 2: entries per input FIFO (power of 2, ≥2).
- WBITS, 4: width of each weight field.
- NIBITS (derived, not overridable): max(1, ceil(log2(NI))).

Ports:
- clk  in  1  sole clock; all state is updated on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_data  in  NI*WIDTH  input i occupies bits [WIDTH*i +: WIDTH].
- i_valid  in  NI  per-input valid.
- i_eop  in  NI  per-input end-of-packet, qualified by i_valid.
- o_ready  out  NI  per-input ready = FIFO i not full. Registered state only; no path from i_ready.
- i_weights  in  NI*WBITS  packets per grant for input i, at [WBITS*i +: WBITS]. A value of 0 is treated as 1.
- o_valid  out  1  output register holds a word.
- o_data  out  WIDTH  output word.
- o_eop  out  1  output word is the last word of its packet.
- o_src  out  NIBITS  index of the input that supplied the word in the output register.
- i_ready  in  1  downstream accepts the word this cycle.

## Operation
- **Input FIFOs**
  - Each input has a FIFO that stores {data, eop}.
  - A push occurs when i_valid[i] && o_ready[i].
  - Read and write pointers wrap modulo DEPTH.
  - The occupancy count is WIDTH-independent and sized to ceil(log2(DEPTH+1)) bits.
  - A full FIFO deasserts o_ready[i]; there is no same-cycle pass-through of a pop into a push.
- **Output register**
  - The output register can load when `!o_valid || i_ready`; call this condition `load_ok`.
  - A pop from FIFO[cur] happens when load_ok, the grant is active, and FIFO[cur] is not empty.
  - A pop loads the output register with {data, eop} and sets o_src = cur.
  - When load_ok holds and there is no pop, o_valid clears.
- **Arbiter state machine** (registers: `cur`, `credit` of WBITS bits, state)
  - **IDLE**
    - Each cycle, scan the non-empty FIFOs in round-robin order starting at cur+1 mod NI and ending at cur.
    - On the first hit j, in the same cycle: set cur = j, load credit = max(1, weight[j]), pop j if load_ok, and go to PKT.
    - If no FIFO is non-empty, remain in IDLE with cur unchanged.
  - **PKT**
    - The grant is locked to cur. Pop when possible.
    - If FIFO[cur] underruns mid-packet, the output bubbles; no other input is served.
  - **Packet boundary** (a popped word has eop = 1)
    - credit decrements by 1.
    - If the new credit is 0, or FIFO[cur] will be empty after this pop, go to IDLE. The next grant then starts scanning from cur+1.
    - Otherwise stay in PKT on cur for its next packet.
- **Weights**
  - Weights are sampled only at grant time. Changes while a grant is held take effect at the next grant.
- **Ordering**
  - Packets are never interleaved on the output.
  - Words within one input keep their order.

## Timing
- **While reset_n is low** (asynchronous):
  - FIFOs empty, pointers 0.
  - o_valid = 0, o_data = 0, o_eop = 0, o_src = 0.
  - o_ready = 0.
  - state = IDLE, cur = NI-1 (so input 0 has first priority), credit = 0.
- **After reset_n deasserts:** o_ready = all ones at the first edge, since FIFOs are empty.
- **Latency:** a word pushed at edge k into an idle merge appears with o_valid = 1 after edge k+1.
- **Throughput:** 1 word/cycle under continuous i_ready.
- **Packet transitions:**
  - Between packets from the same input (credit remaining, FIFO non-empty): no bubble.
  - Re-arbitration in IDLE takes no extra cycle beyond the pop, so switching inputs costs 0 bubbles when the next FIFO is already non-empty.
- **Stall:** when o_valid && !i_ready, the output register and all arbiter state hold. FIFOs continue accepting pushes until full.
- **Reset mid-packet:** all state is discarded immediately. The partially transferred packet is lost; downstream must tolerate this.
- **NI = 1:** the arbiter degenerates. cur stays 0, and o_src is a 1-bit constant 0.

## Test plan
- **Single input, single word.** NI=2. Push a one-word packet (data 0xA5, eop=1) on input 1 at edge 0.
  - Required: o_valid=1, o_data=0xA5, o_src=1, o_eop=1 after edge 1.
  - Required: state returns to IDLE.
- **Weighted round-robin.** Weights {0:3, 1:1}. Both FIFOs are continuously fed with one-word packets; i_ready=1.
  - Required o_src sequence: 0,0,0,1,0,0,0,1…
  - Set weight 0 to 0; required sequence: 0,1,0,1.
- **Packet atomicity.** Input 0 sends a 4-word packet with a 2-cycle gap after word 2. Input 1 is valid throughout.
  - Required: o_valid bubbles during the gap; no o_src=1 word appears until input 0's eop is popped.
- **Backpressure.** DEPTH=2, i_ready=0 for 10 cycles, input 0 pushing continuously.
  - Required: exactly 3 words accepted (1 output register + 2 FIFO), then o_ready[0]=0.
  - Required: on i_ready=1, words drain in order with no loss or duplication.
- **Reset during activity.** Assert reset_n=0 mid-packet.
  - Required: o_valid, o_data, o_eop, o_src and o_ready go to 0 without waiting for a clock edge.
  - Required: after release, o_ready=all ones and the first grant goes to input 0 when both inputs are valid.
